instr_decode_stage: RTL and testbench
=====================================

# instr_decode_stage

Registered instruction-decode stage for the single-cycle MIPS datapath, performing the inverse of the instruction encoder. It accepts a 32-bit instruction word and its PC+4 over a valid/ready handshake, splits it into MIPS fields, and classifies the format. Results are presented one cycle later on a second valid/ready handshake. A two-entry skid buffer sustains one instruction per cycle under downstream back-pressure, and a synchronous flush discards in-flight entries.

## Interface
- `WL`, default 32: instruction/address word length; field positions below assume 32.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: synchronous active-low reset.
- `flush`, input, 1: synchronous discard of all buffered entries.
- `in_valid`, input, 1: `in_instr`/`in_pc4` are valid.
- `in_ready`, output, 1: stage can accept this cycle.
- `in_instr`, input, WL: raw instruction word.
- `in_pc4`, input, WL: PC+4 of that instruction.
- `out_valid`, output, 1: decoded entry is valid.
- `out_ready`, input, 1: consumer takes the entry this cycle.
- `out_instr`, output, WL: raw word, passed through.
- `out_opcode`, output, 6: bits [31:26].
- `out_rs`, output, 5: bits [25:21].
- `out_rt`, output, 5: bits [20:16].
- `out_rd`, output, 5: bits [15:11].
- `out_shamt`, output, 5: bits [10:6].
- `out_funct`, output, 6: bits [5:0].
- `out_imm_sext`, output, WL: bits [15:0] sign-extended.
- `out_imm_zext`, output, WL: bits [15:0] zero-extended.
- `out_jtarget`, output, WL: {in_pc4[31:28], instr[25:0], 2'b00}.
- `out_fmt`, output, 2: 00 R, 01 I, 10 J, 11 ILLEGAL.

## Operation
- Transfer occurs on `in_valid & in_ready` (input) and `out_valid & out_ready` (output).
- Decode is combinational on the input path; the decoded bundle is stored, not the raw word only.
- Format classification:
  - opcode 0x00 → R.
  - 0x02, 0x03 → J.
  - 0x01, 0x04–0x0F, 0x20, 0x21, 0x23, 0x24, 0x25, 0x28, 0x29, 0x2B → I.
  - All others → ILLEGAL. Fields are still extracted.
- Storage is a main output register plus one skid register. State is one of EMPTY, ONE, TWO.
  - EMPTY: accept → ONE.
  - ONE: accept without output take → TWO (new entry to skid). Accept with take → ONE (new entry to main). Take only → EMPTY.
  - TWO: take → ONE (skid moves to main). No accept is possible.
- `in_ready` = rst_n & (state != TWO).
- `out_valid` = (state != EMPTY).
- Order is strictly FIFO. No entry is duplicated or dropped except by flush or reset.
- Flush: next state EMPTY. An `in_valid` in the flush cycle is not stored, even if `in_ready` was high.
- Reset dominates flush.
- Reset: state EMPTY. All `out_*` data registers = 0, `out_valid` = 0, `in_ready` = 0 while `rst_n` = 0, then 1.
- Data outputs hold their value while `out_valid & ~out_ready`. They are don't-care when `out_valid` = 0, but are zero after reset/flush.

## Timing
- Latency: an instruction accepted at edge N appears with `out_valid` = 1 after edge N (one cycle), provided the main register is free.
- Throughput: one instruction per cycle with `out_ready` held high.
- Back-pressure: `in_ready` falls in the cycle after the second unconsumed accept. It rises the cycle after the first take in TWO.
- `in_ready` depends only on registered state, with no combinational path from `out_ready`.
- Sign extension: bit 15 replicated to [WL-1:16]. Zero extension fills with 0.
- `out_jtarget` uses the PC+4 captured with the same instruction, not the current `in_pc4`.

## Structure
- Shared package `mips_pkg`:
  - opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_LW, OP_SW, …).
  - format encoding constants FMT_R/FMT_I/FMT_J/FMT_ILL.
  - field bit-position localparams.
- One sub-module, `instr_field_split`: purely combinational, taking instr and pc4 and producing all fields, extensions, jtarget and fmt. It is instantiated once on the input path.
- The top level holds the two bundle registers, the state register and the handshake logic.

## Test plan
- R-type, streamed: `add $3,$1,$2` = 0x00221820 with out_ready=1 → one cycle later: rs=1, rt=2, rd=3, shamt=0, funct=0x20, fmt=00.
- I-type extension: `addi` word 0x2022FFFF → imm_sext=0xFFFFFFFF, imm_zext=0x0000FFFF, fmt=01. Word 0x8C010004 (lw) → opcode 0x23, imm_sext=4.
- J-type target: instr 0x08000010 with pc4=0x40000004 → jtarget=0x40000040, fmt=10. Opcode 0x3F → fmt=11.
- Back-pressure: three back-to-back valid words A,B,C with out_ready=0.
  - A and B accepted; in_ready=0 after B; out shows A held stable.
  - Raise out_ready → A, B, C emerge in order with no gaps or duplicates.
- Flush/reset mid-stream: in state TWO, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, nothing emitted. Repeat with rst_n=0 → all outputs 0, in_ready=0 during reset.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, format codes, field positions.
// Also holds the opcode-to-format classifier used by the decode stage.
package mips_pkg;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned RS_MSB    = 25;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_MSB    = 20;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_MSB    = 15;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned SH_MSB    = 10;
    localparam int unsigned SH_LSB    = 6;
    localparam int unsigned FN_MSB    = 5;
    localparam int unsigned FN_LSB    = 0;
    localparam int unsigned IMM_MSB   = 15;
    localparam int unsigned JIDX_MSB  = 25;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [1:0] FMT_R   = 2'b00;
    localparam logic [1:0] FMT_I   = 2'b01;
    localparam logic [1:0] FMT_J   = 2'b10;
    localparam logic [1:0] FMT_ILL = 2'b11;

    function automatic logic [1:0] fmt_of(input logic [5:0] op);
        logic is_i;
        is_i = (op == OP_REGIMM)
            || (op >= OP_BEQ && op <= OP_LUI)
            || (op == OP_LB)  || (op == OP_LH)
            || (op == OP_LW)  || (op == OP_LBU)
            || (op == OP_LHU) || (op == OP_SB)
            || (op == OP_SH)  || (op == OP_SW);
        if (op == OP_RTYPE)
            return FMT_R;
        else if (op == OP_J || op == OP_JAL)
            return FMT_J;
        else if (is_i)
            return FMT_I;
        else
            return FMT_ILL;
    endfunction

endpackage

// File: rtl/instr_field_split.sv
// Combinational MIPS field splitter: instr/pc4 in; fields, immediate
// extensions, jump target and format class out.
module instr_field_split
    import mips_pkg::*;
#(
    parameter int WL = 32
) (
    input  logic [WL-1:0] instr_i,
    input  logic [WL-1:0] pc4_i,
    output logic [5:0]    opcode_o,
    output logic [4:0]    rs_o,
    output logic [4:0]    rt_o,
    output logic [4:0]    rd_o,
    output logic [4:0]    shamt_o,
    output logic [5:0]    funct_o,
    output logic [WL-1:0] imm_sext_o,
    output logic [WL-1:0] imm_zext_o,
    output logic [WL-1:0] jtarget_o,
    output logic [1:0]    fmt_o
);

    // Only the region bits of PC+4 feed the jump target.
    logic unused_pc4;
    assign unused_pc4 = ^pc4_i[WL-5:0];

    assign opcode_o   = instr_i[OP_MSB:OP_LSB];
    assign rs_o       = instr_i[RS_MSB:RS_LSB];
    assign rt_o       = instr_i[RT_MSB:RT_LSB];
    assign rd_o       = instr_i[RD_MSB:RD_LSB];
    assign shamt_o    = instr_i[SH_MSB:SH_LSB];
    assign funct_o    = instr_i[FN_MSB:FN_LSB];
    assign imm_sext_o = {{(WL-16){instr_i[IMM_MSB]}}, instr_i[IMM_MSB:0]};
    assign imm_zext_o = {{(WL-16){1'b0}}, instr_i[IMM_MSB:0]};
    assign jtarget_o  = {pc4_i[WL-1:WL-4], instr_i[JIDX_MSB:0], 2'b00};
    assign fmt_o      = fmt_of(instr_i[OP_MSB:OP_LSB]);

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage with a 2-entry skid buffer (main + skid).
// Ports: in_* handshake + word/pc4, out_* handshake + decoded fields, flush.
module instr_decode_stage
    import mips_pkg::*;
#(
    parameter int WL = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WL-1:0] in_instr,
    input  logic [WL-1:0] in_pc4,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WL-1:0] out_instr,
    output logic [5:0]    out_opcode,
    output logic [4:0]    out_rs,
    output logic [4:0]    out_rt,
    output logic [4:0]    out_rd,
    output logic [4:0]    out_shamt,
    output logic [5:0]    out_funct,
    output logic [WL-1:0] out_imm_sext,
    output logic [WL-1:0] out_imm_zext,
    output logic [WL-1:0] out_jtarget,
    output logic [1:0]    out_fmt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam int BW = 4 * WL + 6 + 6 + 4 * 5 + 2;

    logic [5:0]    d_opcode;
    logic [4:0]    d_rs, d_rt, d_rd, d_shamt;
    logic [5:0]    d_funct;
    logic [WL-1:0] d_sext, d_zext, d_jt;
    logic [1:0]    d_fmt;
    logic [BW-1:0] dec;

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] main_q, main_d;
    logic [BW-1:0] skid_q, skid_d;
    logic          acc, take;

    instr_field_split #(.WL(WL)) u_split (
        .instr_i    (in_instr),
        .pc4_i      (in_pc4),
        .opcode_o   (d_opcode),
        .rs_o       (d_rs),
        .rt_o       (d_rt),
        .rd_o       (d_rd),
        .shamt_o    (d_shamt),
        .funct_o    (d_funct),
        .imm_sext_o (d_sext),
        .imm_zext_o (d_zext),
        .jtarget_o  (d_jt),
        .fmt_o      (d_fmt)
    );

    assign dec = {in_instr, d_opcode, d_rs, d_rt, d_rd, d_shamt,
                  d_funct, d_sext, d_zext, d_jt, d_fmt};

    assign in_ready  = rst_n & (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign acc       = in_valid & in_ready;
    assign take      = out_valid & out_ready;

    assign {out_instr, out_opcode, out_rs, out_rt, out_rd, out_shamt,
            out_funct, out_imm_sext, out_imm_zext, out_jtarget,
            out_fmt} = main_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Discard everything, including a same-cycle accept.
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        main_d  = dec;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && take) begin
                        main_d = dec;
                    end else if (acc) begin
                        skid_d  = dec;
                        state_d = ST_TWO;
                    end else if (take) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (take) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: queue-based FIFO model,
// per-cycle compare process, directed plan cases and random traffic.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc4 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
    logic [5:0]  out_funct;
    logic [31:0] out_imm_sext, out_imm_zext, out_jtarget;
    logic [1:0]  out_fmt;

    int n_checks = 0;
    int n_fails  = 0;
    bit chk_en   = 1'b0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    ent_t mq[$];
    bit   zero_exp = 1'b0;

    always #5 clk = ~clk;

    instr_decode_stage #(.WL(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc4       (in_pc4),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_opcode   (out_opcode),
        .out_rs       (out_rs),
        .out_rt       (out_rt),
        .out_rd       (out_rd),
        .out_shamt    (out_shamt),
        .out_funct    (out_funct),
        .out_imm_sext (out_imm_sext),
        .out_imm_zext (out_imm_zext),
        .out_jtarget  (out_jtarget),
        .out_fmt      (out_fmt)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fmt(input int op);
        if (op == 0) return 2'd0;
        if (op == 2 || op == 3) return 2'd2;
        if (op == 1 || (op >= 4 && op <= 15)) return 2'd1;
        if (op == 'h20 || op == 'h21 || op == 'h23 || op == 'h24 ||
            op == 'h25 || op == 'h28 || op == 'h29 || op == 'h2B)
            return 2'd1;
        return 2'd3;
    endfunction

    task automatic check_entry(input ent_t e);
        logic [31:0] w, imm, sx;
        w   = e.instr;
        imm = w & 32'h0000FFFF;
        sx  = (imm >= 32'h8000) ? (imm | 32'hFFFF0000) : imm;
        check("instr",  out_instr, w);
        check("opcode", {26'd0, out_opcode}, (w >> 26) & 32'h3F);
        check("rs",     {27'd0, out_rs},     (w >> 21) & 32'h1F);
        check("rt",     {27'd0, out_rt},     (w >> 16) & 32'h1F);
        check("rd",     {27'd0, out_rd},     (w >> 11) & 32'h1F);
        check("shamt",  {27'd0, out_shamt},  (w >> 6) & 32'h1F);
        check("funct",  {26'd0, out_funct},  w & 32'h3F);
        check("sext",   out_imm_sext, sx);
        check("zext",   out_imm_zext, imm);
        check("jtarget", out_jtarget,
              (e.pc4 & 32'hF0000000) | ((w & 32'h03FFFFFF) << 2));
        check("fmt", {30'd0, out_fmt}, {30'd0, ref_fmt(int'(w >> 26))});
    endtask

    task automatic check_zero();
        check("z_instr", out_instr, 0);
        check("z_fields", {out_opcode, out_rs, out_rt, out_rd,
                           out_shamt, out_funct, out_fmt}, 0);
        check("z_sext", out_imm_sext, 0);
        check("z_zext", out_imm_zext, 0);
        check("z_jt", out_jtarget, 0);
    endtask

    // Compare, then advance the FIFO model by what the coming edge does.
    always @(negedge clk) begin
        if (chk_en) begin
            bit mv, acc, take;
            ent_t e;
            mv = (mq.size() > 0);
            check("out_valid", {31'd0, out_valid}, {31'd0, mv});
            check("in_ready", {31'd0, in_ready},
                  {31'd0, (rst_n && mq.size() < 2)});
            if (mv)
                check_entry(mq[0]);
            else if (zero_exp)
                check_zero();
            if (!rst_n || flush) begin
                mq.delete();
                zero_exp = 1'b1;
            end else begin
                acc  = in_valid && (mq.size() < 2);
                take = mv && out_ready;
                if (take) void'(mq.pop_front());
                if (acc) begin
                    e.instr = in_instr;
                    e.pc4   = in_pc4;
                    mq.push_back(e);
                    zero_exp = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] p);
        in_valid = 1'b1;
        in_instr = w;
        in_pc4   = p;
        step();
        in_valid = 1'b0;
    endtask

    localparam logic [31:0] WA = 32'h00221820;
    localparam logic [31:0] WB = 32'h2022FFFF;
    localparam logic [31:0] WC = 32'h8C010004;

    initial begin
        step();
        chk_en = 1'b1;
        step();
        check("rst_in_ready", {31'd0, in_ready}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_instr", out_instr, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", {31'd0, in_ready}, 1);

        // Streamed decode, plan literals
        out_ready = 1'b1;
        send(WA, 32'h00400004);
        @(negedge clk);
        check("add_rs", {27'd0, out_rs}, 1);
        check("add_rt", {27'd0, out_rt}, 2);
        check("add_rd", {27'd0, out_rd}, 3);
        check("add_funct", {26'd0, out_funct}, 32'h20);
        check("add_fmt", {30'd0, out_fmt}, 0);
        step();
        send(WB, 32'h00400008);
        @(negedge clk);
        check("addi_sext", out_imm_sext, 32'hFFFFFFFF);
        check("addi_zext", out_imm_zext, 32'h0000FFFF);
        check("addi_fmt", {30'd0, out_fmt}, 1);
        step();
        send(WC, 32'h0040000C);
        @(negedge clk);
        check("lw_op", {26'd0, out_opcode}, 32'h23);
        check("lw_sext", out_imm_sext, 4);
        step();
        send(32'h08000010, 32'h40000004);
        @(negedge clk);
        check("j_target", out_jtarget, 32'h40000040);
        check("j_fmt", {30'd0, out_fmt}, 2);
        step();
        send(32'hFC000000, 32'h0);
        @(negedge clk);
        check("ill_fmt", {30'd0, out_fmt}, 3);
        step();
        step();

        // Back-pressure: A, B, C with out_ready low
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = WA;
        step();
        in_instr = WB;
        step();
        in_instr = WC;
        check("bp_ready_low", {31'd0, in_ready}, 0);
        check("bp_hold_a", out_instr, WA);
        step();
        check("bp_still_a", out_instr, WA);
        out_ready = 1'b1;
        step();
        check("bp_b", out_instr, WB);
        step();
        check("bp_c", out_instr, WC);
        in_valid = 1'b0;
        step();
        check("bp_drain", {31'd0, out_valid}, 0);

        // Flush in TWO with a concurrent valid word
        out_ready = 1'b0;
        send(WA, 0);
        send(WB, 0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = WC;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", {31'd0, out_valid}, 0);
        check("fl_ready", {31'd0, in_ready}, 1);
        check("fl_zero", out_instr, 0);

        // Reset in TWO
        send(WA, 0);
        send(WB, 0);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_instr = WC;
        #1;
        check("rs_ready", {31'd0, in_ready}, 0);
        step();
        check("rs_valid", {31'd0, out_valid}, 0);
        check("rs_zero", out_jtarget | out_imm_sext | out_instr, 0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            r         = $urandom_range(0, 3);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 60) == 0);
            rst_n     = ($urandom_range(0, 200) != 0);
            in_instr  = $urandom;
            if (r == 0) in_instr[31:26] = 6'h00;
            if (r == 1) in_instr[31:26] = 6'($urandom_range(1, 15));
            in_pc4    = $urandom;
            step();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
